// File: rtl/write_back_stage.sv
// Write-back stage: source mux, 2-entry head/skid buffer, register-file write port, forwarding tap.
// Latency: an accepted entry appears on rf_* the cycle after acceptance; one entry per cycle sustained.
// Backpressure: in_ready is registered and drops only when the skid entry is occupied; nothing is lost.
module write_back_stage #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int CNT_W     = 16,
    parameter bit ZERO_PROT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_link,
    input  logic [1:0]        in_sel,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    input  logic              rf_ready,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] ans_wb,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int HALF = DATA_W / 2;

    // Head entry (drives the write port) and skid entry (absorbs one entry of backpressure)
    logic              h_vld_q, h_vld_d;
    logic              h_we_q,  h_we_d;
    logic [ADDR_W-1:0] h_rd_q,  h_rd_d;
    logic [DATA_W-1:0] h_dat_q, h_dat_d;
    logic              s_vld_q, s_vld_d;
    logic              s_we_q,  s_we_d;
    logic [ADDR_W-1:0] s_rd_q,  s_rd_d;
    logic [DATA_W-1:0] s_dat_q, s_dat_d;

    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] ans_q, ans_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] src_dat;
    logic              src_we;
    logic              accept;
    logic              drain;
    logic              wr_done;

    // Result source select, resolved before the entry is captured
    always_comb begin
        src_dat = in_alu;
        case (in_sel)
            2'b00:   src_dat = in_alu;
            2'b01:   src_dat = in_mem;
            2'b10:   src_dat = in_link;
            default: src_dat = {{(DATA_W-HALF){in_mem[HALF-1]}}, in_mem[HALF-1:0]};
        endcase
    end

    // Writes to r0 are turned into non-writing entries that still retire
    assign src_we  = in_we & ~(ZERO_PROT & (in_rd == '0));

    assign accept  = in_valid & in_ready_q;
    assign drain   = h_vld_q & (~h_we_q | rf_ready);
    assign wr_done = h_vld_q & h_we_q & rf_ready;

    // Buffer next state: skid refills head on drain, otherwise new entries fill the first free slot
    always_comb begin
        h_vld_d = h_vld_q;
        h_we_d  = h_we_q;
        h_rd_d  = h_rd_q;
        h_dat_d = h_dat_q;
        s_vld_d = s_vld_q;
        s_we_d  = s_we_q;
        s_rd_d  = s_rd_q;
        s_dat_d = s_dat_q;
        ans_d   = ans_q;
        cnt_d   = cnt_q;

        if (drain) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (s_vld_q) begin
                // in_ready was low, so no entry can be accepted in this cycle
                h_vld_d = 1'b1;
                h_we_d  = s_we_q;
                h_rd_d  = s_rd_q;
                h_dat_d = s_dat_q;
                s_vld_d = 1'b0;
            end else if (accept) begin
                h_vld_d = 1'b1;
                h_we_d  = src_we;
                h_rd_d  = in_rd;
                h_dat_d = src_dat;
            end else begin
                h_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!h_vld_q) begin
                h_vld_d = 1'b1;
                h_we_d  = src_we;
                h_rd_d  = in_rd;
                h_dat_d = src_dat;
            end else begin
                s_vld_d = 1'b1;
                s_we_d  = src_we;
                s_rd_d  = in_rd;
                s_dat_d = src_dat;
            end
        end

        if (wr_done) begin
            ans_d = h_dat_q;
        end

        in_ready_d = ~s_vld_d;
    end

    // State registers; reset drops any in-flight entry including one offered this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            h_vld_q    <= 1'b0;
            h_we_q     <= 1'b0;
            h_rd_q     <= '0;
            h_dat_q    <= '0;
            s_vld_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_rd_q     <= '0;
            s_dat_q    <= '0;
            in_ready_q <= 1'b1;
            ans_q      <= '0;
            cnt_q      <= '0;
        end else begin
            h_vld_q    <= h_vld_d;
            h_we_q     <= h_we_d;
            h_rd_q     <= h_rd_d;
            h_dat_q    <= h_dat_d;
            s_vld_q    <= s_vld_d;
            s_we_q     <= s_we_d;
            s_rd_q     <= s_rd_d;
            s_dat_q    <= s_dat_d;
            in_ready_q <= in_ready_d;
            ans_q      <= ans_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign rf_we      = h_vld_q & h_we_q;
    assign rf_addr    = h_rd_q;
    assign rf_data    = h_dat_q;
    assign fwd_valid  = rf_we;
    assign fwd_addr   = h_rd_q;
    assign fwd_data   = h_dat_q;
    assign ans_wb     = ans_q;
    assign retire_cnt = cnt_q;

endmodule
